// File: rtl/cat_loader_pkg.sv
// Shared types and sizing helpers for the cat image loader.
package cat_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        CSETUP,
        CACCESS,
        DONE
    } apb_state_e;

    localparam int CTRL_START_BIT = 0;

    function automatic int pix_per_word(input int amba_word, input int pixel_width);
        return amba_word / pixel_width;
    endfunction

    function automatic int num_words(input int num_pixels, input int ppw);
        return (num_pixels + ppw - 1) / ppw;
    endfunction

endpackage

// File: rtl/cat_pixel_packer.sv
// Packs byte pixels LSB-first into one APB word; a frame's final pixel closes the word early.
module cat_pixel_packer
    import cat_loader_pkg::*;
#(
    parameter int Amba_Word   = 24,
    parameter int Pixel_Width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept,
    input  logic [Pixel_Width-1:0] pix_data,
    input  logic                   final_pix,
    input  logic                   take,
    output logic [Amba_Word-1:0]   word,
    output logic                   complete
);

    localparam int PPW    = pix_per_word(Amba_Word, Pixel_Width);
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);

    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [Amba_Word-1:0] pack_q, pack_d;
    logic                 complete_q, complete_d;

    always_comb begin
        slot_d     = slot_q;
        pack_d     = pack_q;
        complete_d = complete_q;
        // Clearing on take leaves unused upper slots of a short final word at zero.
        if (take) begin
            pack_d     = '0;
            complete_d = 1'b0;
        end
        if (accept) begin
            pack_d[int'(slot_q) * Pixel_Width +: Pixel_Width] = pix_data;
            if (final_pix || slot_q == LAST_SLOT) begin
                complete_d = 1'b1;
                slot_d     = '0;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            pack_q     <= '0;
            complete_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            complete_q <= complete_d;
        end
    end

    assign word     = pack_q;
    assign complete = complete_q;

endmodule

// File: rtl/cat_image_loader.sv
// APB write master: streams a packed pixel frame into consecutive image words,
// then writes the start bit to the control register and pulses done.
module cat_image_loader
    import cat_loader_pkg::*;
#(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 13,
    parameter int Pixel_Width     = 8,
    parameter int Num_Pixels      = 12288,
    parameter int Ctrl_Addr       = 0,
    parameter int Img_Base        = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic [Pixel_Width-1:0]     pix_data,
    input  logic                       pix_last,
    output logic                       pix_ready,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA,
    output logic                       busy,
    output logic                       done,
    output logic                       frame_err
);

    localparam int PPW    = pix_per_word(Amba_Word, Pixel_Width);
    localparam int NWORDS = num_words(Num_Pixels, PPW);
    localparam int CNT_W  = (Num_Pixels > 1) ? $clog2(Num_Pixels) : 1;

    localparam logic [CNT_W-1:0]           LAST_PIX  = CNT_W'(Num_Pixels - 1);
    localparam logic [Amba_Addr_Depth-1:0] BASE_ADDR = Amba_Addr_Depth'(Img_Base);
    localparam logic [Amba_Addr_Depth-1:0] LAST_ADDR = Amba_Addr_Depth'(Img_Base + NWORDS - 1);
    localparam logic [Amba_Addr_Depth-1:0] CTRL_ADDR = Amba_Addr_Depth'(Ctrl_Addr);
    localparam logic [Amba_Word-1:0]       CTRL_WORD = Amba_Word'(1 << CTRL_START_BIT);

    if (Img_Base + NWORDS > (1 << Amba_Addr_Depth)) begin : g_addr_range_chk
        $error("cat_image_loader: image words do not fit in the APB address space");
    end
    if (PPW < 1 || (Amba_Word % Pixel_Width) != 0) begin : g_pack_chk
        $error("cat_image_loader: Amba_Word must be a whole multiple of Pixel_Width");
    end

    apb_state_e                 state_q, state_d;
    logic [Amba_Addr_Depth-1:0] paddr_q, paddr_d;
    logic [Amba_Addr_Depth-1:0] next_addr_q, next_addr_d;
    logic [Amba_Word-1:0]       pwdata_q, pwdata_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic                       pend_q, pend_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_q, lock_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                 accept;
    logic                 is_final;
    logic                 mismatch;
    logic                 can_take;
    logic                 take;
    logic [Amba_Word-1:0] pk_word;
    logic                 pk_complete;

    // pwdata_q doubles as the holding register; pend_q marks a word not yet started.
    assign can_take  = (state_q == IDLE && !pend_q) ||
                       (state_q == ACCESS && paddr_q != LAST_ADDR);
    assign take      = pk_complete && can_take;
    assign pix_ready = !rst && !lock_q && (!pk_complete || take);
    assign accept    = pix_valid && pix_ready;
    assign is_final  = (count_q == LAST_PIX);
    assign mismatch  = (pix_last != is_final);

    cat_pixel_packer #(
        .Amba_Word  (Amba_Word),
        .Pixel_Width(Pixel_Width)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .pix_data (pix_data),
        .final_pix(is_final),
        .take     (take),
        .word     (pk_word),
        .complete (pk_complete)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        next_addr_d = next_addr_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pend_d      = pend_q;
        count_d     = count_q;
        lock_d      = lock_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                penable_d = 1'b0;
                if (paddr_q == LAST_ADDR) begin
                    state_d  = CSETUP;
                    paddr_d  = CTRL_ADDR;
                    pwdata_d = CTRL_WORD;
                end else if (take) begin
                    state_d = SETUP;
                end else begin
                    state_d  = IDLE;
                    psel_d   = 1'b0;
                    pwrite_d = 1'b0;
                end
            end
            CSETUP: begin
                state_d   = CACCESS;
                penable_d = 1'b1;
            end
            CACCESS: begin
                state_d   = DONE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            DONE: begin
                state_d     = IDLE;
                next_addr_d = BASE_ADDR;
                lock_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            pwdata_d    = pk_word;
            paddr_d     = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            if (state_q == IDLE) begin
                pend_d = 1'b1;
            end
        end

        // The frame ends on the pixel count; pix_last only feeds the error flag.
        if (accept) begin
            busy_d = 1'b1;
            if (is_final) begin
                count_d = '0;
                lock_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (count_q == '0) begin
                err_d = mismatch;
            end else if (mismatch) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            next_addr_q <= BASE_ADDR;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pend_q      <= 1'b0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            next_addr_q <= next_addr_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            lock_q      <= lock_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_cat_image_loader.sv
// Directed bench for cat_image_loader: a 7-pixel instance and a 12-pixel instance.
module tb_cat_image_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: Num_Pixels = 7
    logic        rst_a, pv_a, pl_a, rdy_a, psel_a, pen_a, pwr_a, busy_a, done_a, err_a;
    logic [7:0]  pd_a;
    logic [12:0] paddr_a;
    logic [23:0] pwdata_a;

    // Instance B: Num_Pixels = 12
    logic        rst_b, pv_b, pl_b, rdy_b, psel_b, pen_b, pwr_b, busy_b, done_b, err_b;
    logic [7:0]  pd_b;
    logic [12:0] paddr_b;
    logic [23:0] pwdata_b;

    cat_image_loader #(.Num_Pixels(7)) dut_a (
        .clk(clk), .rst(rst_a), .pix_valid(pv_a), .pix_data(pd_a), .pix_last(pl_a),
        .pix_ready(rdy_a), .PADDR(paddr_a), .PSEL(psel_a), .PENABLE(pen_a), .PWRITE(pwr_a),
        .PWDATA(pwdata_a), .busy(busy_a), .done(done_a), .frame_err(err_a)
    );

    cat_image_loader #(.Num_Pixels(12)) dut_b (
        .clk(clk), .rst(rst_b), .pix_valid(pv_b), .pix_data(pd_b), .pix_last(pl_b),
        .pix_ready(rdy_b), .PADDR(paddr_b), .PSEL(psel_b), .PENABLE(pen_b), .PWRITE(pwr_b),
        .PWDATA(pwdata_b), .busy(busy_b), .done(done_b), .frame_err(err_b)
    );

    typedef struct packed {
        logic        psel;
        logic        pen;
        logic        pwr;
        logic        done;
        logic [12:0] addr;
        logic [23:0] data;
    } tr_t;

    tr_t trace_a[$];
    tr_t trace_b[$];

    always @(negedge clk) trace_a.push_back({psel_a, pen_a, pwr_a, done_a, paddr_a, pwdata_a});
    always @(negedge clk) trace_b.push_back({psel_b, pen_b, pwr_b, done_b, paddr_b, pwdata_b});

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [42:0] exp;
    } vec_t;

    vec_t        vecs[15];
    logic [36:0] exp_w[8];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input logic [7:0] d, input logic l,
                           input logic rdy, input logic ps, input logic pe, input logic [12:0] ad,
                           input logic [23:0] dat, input logic dn, input logic bz, input logic er);
        vecs[i].v   = v;
        vecs[i].d   = d;
        vecs[i].l   = l;
        vecs[i].exp = {rdy, ps, pe, ad, dat, dn, bz, er};
    endtask

    function automatic logic [42:0] obs_a();
        return {rdy_a, psel_a, pen_a, paddr_a, pwdata_a, done_a, busy_a, err_a};
    endfunction

    task automatic send_px(input bit which, input logic [7:0] d, input bit last);
        int t = 0;
        if (which) begin pv_b = 1'b1; pd_b = d; pl_b = last; end
        else       begin pv_a = 1'b1; pd_a = d; pl_a = last; end
        while (!(which ? rdy_b : rdy_a)) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                check("ready_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        pv_a = 1'b0;
        pv_b = 1'b0;
        pl_a = 1'b0;
        pl_b = 1'b0;
    endtask

    task automatic wait_done(input bit which);
        int t = 0;
        while (!(which ? done_b : done_a)) begin
            @(posedge clk); #1;
            t++;
            if (t > 300) begin
                check("done_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Walks a trace window: phase legality, captured writes and done pulses.
    task automatic check_frame(input bit which, input int s, input int e, input int n_exp);
        logic [36:0] got[$];
        tr_t cur, prv;
        int  dn = 0;
        for (int i = s; i < e; i++) begin
            cur = which ? trace_b[i] : trace_a[i];
            if (cur.done) dn++;
            if (i > s && cur.psel && cur.pen) begin
                prv = which ? trace_b[i-1] : trace_a[i-1];
                check("apb_phase", {prv.psel, prv.pen, prv.pwr, prv.addr, prv.data},
                      {1'b1, 1'b0, 1'b1, cur.addr, cur.data});
                got.push_back({cur.addr, cur.data});
            end
        end
        check("n_writes", 64'(got.size()), 64'(n_exp));
        for (int k = 0; k < n_exp && k < got.size(); k++)
            check($sformatf("write%0d", k), 64'(got[k]), 64'(exp_w[k]));
        check("done_pulses", 64'(dn), 64'd1);
    endtask

    task automatic set_exp3(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2);
        exp_w[0] = {13'd1, w0};
        exp_w[1] = {13'd2, w1};
        exp_w[2] = {13'd3, w2};
        exp_w[3] = {13'd0, 24'd1};
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int s1, s2, t;

        // Full-rate 7-pixel frame, cycle by cycle; last row starts the next frame at once.
        set_vec( 0, 1, 8'h01, 0, 1, 0, 0, 13'd0, 24'h000000, 0, 0, 0);
        set_vec( 1, 1, 8'h02, 0, 1, 0, 0, 13'd0, 24'h000000, 0, 1, 0);
        set_vec( 2, 1, 8'h03, 0, 1, 0, 0, 13'd0, 24'h000000, 0, 1, 0);
        set_vec( 3, 1, 8'h04, 0, 1, 0, 0, 13'd0, 24'h000000, 0, 1, 0);
        set_vec( 4, 1, 8'h05, 0, 1, 0, 0, 13'd1, 24'h030201, 0, 1, 0);
        set_vec( 5, 1, 8'h06, 0, 1, 1, 0, 13'd1, 24'h030201, 0, 1, 0);
        set_vec( 6, 1, 8'h07, 1, 1, 1, 1, 13'd1, 24'h030201, 0, 1, 0);
        set_vec( 7, 0, 8'h00, 0, 0, 1, 0, 13'd2, 24'h060504, 0, 1, 0);
        set_vec( 8, 0, 8'h00, 0, 0, 1, 1, 13'd2, 24'h060504, 0, 1, 0);
        set_vec( 9, 0, 8'h00, 0, 0, 1, 0, 13'd3, 24'h000007, 0, 1, 0);
        set_vec(10, 0, 8'h00, 0, 0, 1, 1, 13'd3, 24'h000007, 0, 1, 0);
        set_vec(11, 0, 8'h00, 0, 0, 1, 0, 13'd0, 24'h000001, 0, 1, 0);
        set_vec(12, 0, 8'h00, 0, 0, 1, 1, 13'd0, 24'h000001, 0, 1, 0);
        set_vec(13, 0, 8'h00, 0, 0, 0, 0, 13'd0, 24'h000001, 1, 0, 0);
        set_vec(14, 1, 8'h31, 0, 1, 0, 0, 13'd0, 24'h000001, 0, 0, 0);

        // Reset held two cycles with a pixel offered.
        rst_a = 1'b1; rst_b = 1'b1;
        pv_a = 1'b1; pd_a = 8'hAA; pl_a = 1'b0;
        pv_b = 1'b1; pd_b = 8'hAA; pl_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset_a%0d", i), 64'(obs_a()), 64'd0);
            check($sformatf("reset_pwrite_a%0d", i), 64'(pwr_a), 64'd0);
        end
        check("reset_b", 64'({rdy_b, psel_b, pen_b, pwr_b, paddr_b, pwdata_b, busy_b, done_b, err_b}), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        pv_a = 1'b0; pv_b = 1'b0;
        #1;
        check("post_reset_a", 64'({rdy_a, psel_a}), 64'b10);
        check("post_reset_b", 64'({rdy_b, psel_b}), 64'b10);

        s1 = trace_a.size();
        for (int i = 0; i < 15; i++) begin
            pv_a = vecs[i].v; pd_a = vecs[i].d; pl_a = vecs[i].l;
            #1;
            check($sformatf("vec%0d", i), 64'(obs_a()), 64'(vecs[i].exp));
            @(posedge clk); #1;
        end
        pv_a = 1'b0;
        s2 = trace_a.size();
        set_exp3(24'h030201, 24'h060504, 24'h000007);
        check_frame(0, s1, s2, 4);

        // Second frame: 0x31 went in on the cycle after done; addresses restart at 1.
        for (int i = 2; i <= 7; i++) send_px(0, 8'h30 + 8'(i), i == 7);
        wait_done(0);
        set_exp3(24'h333231, 24'h363534, 24'h000037);
        check_frame(0, s2, trace_a.size(), 4);

        // pix_last on the 4th pixel; frame still completes on count.
        s1 = trace_a.size();
        for (int i = 1; i <= 7; i++) begin
            send_px(0, 8'h40 + 8'(i), i == 4);
            if (i == 4) check("err_early_last", 64'(err_a), 64'd1);
        end
        check("err_sticky", 64'(err_a), 64'd1);
        wait_done(0);
        set_exp3(24'h434241, 24'h464544, 24'h000047);
        check_frame(0, s1, trace_a.size(), 4);

        // Next frame's first pixel clears the flag; then reset during word 2 ACCESS.
        send_px(0, 8'h51, 0);
        check("err_cleared", 64'(err_a), 64'd0);
        for (int i = 2; i <= 6; i++) send_px(0, 8'h50 + 8'(i), 0);
        t = 0;
        while (!(psel_a && pen_a && paddr_a == 13'd2) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reach_access2", 64'(t < 50), 64'd1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("midframe_reset", 64'(obs_a()), 64'd0);
        rst_a = 1'b0;
        #1;
        s1 = trace_a.size();
        for (int i = 1; i <= 7; i++) send_px(0, 8'h60 + 8'(i), i == 7);
        wait_done(0);
        set_exp3(24'h636261, 24'h666564, 24'h000067);
        check_frame(0, s1, trace_a.size(), 4);
        check("after_reset_err", 64'(err_a), 64'd0);

        // 12-pixel frame with random single-cycle gaps.
        s1 = trace_b.size();
        for (int i = 1; i <= 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pv_b = 1'b0;
                @(posedge clk); #1;
            end
            send_px(1, 8'(i), i == 12);
        end
        wait_done(1);
        exp_w[0] = {13'd1, 24'h030201};
        exp_w[1] = {13'd2, 24'h060504};
        exp_w[2] = {13'd3, 24'h090807};
        exp_w[3] = {13'd4, 24'h0C0B0A};
        exp_w[4] = {13'd0, 24'h000001};
        check_frame(1, s1, trace_b.size(), 5);
        check("gap_err_b", 64'(err_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
